turn_sequencer: RTL
===================

# turn_sequencer

Consumes the packed per-node turn decisions produced by the path direction planner and replays them one at a time as the bot reaches each node. On every node-detect pulse from the line sensor front end, it presents the next 2-bit turn command to the motor controller. It holds that command under a valid/done handshake, then advances. It sits between the planner and the motor/turn controller.

## Interface
- MAX_TURNS, 12: direction slots in the packed vector.
- DIR_W, 2: bits per direction.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse; captures `directions` and `num_turns`.
- directions  in  MAX_TURNS*DIR_W (24)  packed turns; slot k at bits [2k+1:2k]; slot 0 is applied first.
- num_turns  in  4  number of valid slots; values > MAX_TURNS saturate to MAX_TURNS.
- node_detect  in  1  one-cycle pulse; the bot is centred on a node.
- turn_done  in  1  one-cycle pulse from the motor controller; the commanded turn is complete.
- turn_cmd  out  2  current turn code (LEFT 01, STRAIGHT 11, RIGHT 10, U_TURN 00).
- turn_valid  out  1  turn_cmd is valid; held until turn_done.
- turn_index  out  4  index of the slot being or about to be executed.
- busy  out  1  high in FOLLOW or TURN.
- path_done  out  1  high in DONE.
- overrun  out  1  sticky; node_detect arrived while in TURN.

## Operation
- States: IDLE, FOLLOW, TURN, DONE. All outputs are registered.
- IDLE:
  - load captures directions and saturated num_turns, and clears turn_index and overrun.
  - If num_turns==0, go to DONE; otherwise go to FOLLOW.
  - node_detect and turn_done are ignored.
- FOLLOW:
  - On node_detect, latch turn_cmd = slot[turn_index], set turn_valid=1, go to TURN.
  - turn_done is ignored.
- TURN:
  - turn_cmd and turn_valid are held stable.
  - On turn_done, clear turn_valid and increment turn_index.
  - If the incremented index equals num_turns, go to DONE; otherwise go to FOLLOW.
  - node_detect in TURN sets overrun and is otherwise dropped, including when it coincides with turn_done.
- DONE: path_done=1. load behaves as in IDLE and starts a new path. Other inputs are ignored.
- load in FOLLOW or TURN is ignored; the current path must complete or be reset.
- turn_index never exceeds num_turns. Slot indexing is on the captured copy, so input changes after load have no effect.
- rst (in any state, including mid-turn) forces IDLE. Reset values: turn_cmd=00, turn_valid=0, turn_index=0, busy=0, path_done=0, overrun=0, captured registers=0.

## Timing
- load at cycle N: busy=1 (or path_done=1 if num_turns==0) at N+1.
- node_detect at cycle N in FOLLOW: turn_cmd valid and turn_valid=1 at N+1.
- turn_done at cycle M in TURN:
  - turn_valid=0 and turn_index+1 at M+1.
  - If that was the last turn, path_done=1 and busy=0 at M+1.
- Earliest next command: node_detect at M+1 gives turn_valid at M+2. The minimum gap between turns is one cycle with turn_valid low.
- rst has priority over every other input in the same cycle.

## Structure
- Shared package holds:
  - the direction codes LEFT/STRAIGHT/RIGHT/U_TURN (the same values the planner uses);
  - MAX_TURNS and DIR_W;
  - the state enum for this block.
- Single module with no sub-module. The slot mux is a simple indexed part-select of the captured vector.

## Test plan
- **Basic replay:** load with directions=24'h00002D (slot0 LEFT, slot1 STRAIGHT, slot2 RIGHT), num_turns=3. Then three cycles of node_detect followed by turn_done 5 cycles later. Required: turn_cmd sequence 01, 11, 10; turn_valid high exactly from node_detect+1 to turn_done; path_done=1 one cycle after the third turn_done.
- **Empty path:** num_turns=0. Required: path_done=1 one cycle after load; node_detect gives no turn_valid.
- **Overrun:** node_detect pulsed twice while in TURN, including once in the same cycle as turn_done. Required: overrun=1, turn_index advances only once, the following FOLLOW waits for a fresh node_detect.
- **Saturation and U-turn:** num_turns=15, directions=24'h000000. Required: twelve U_TURN (00) commands, then path_done.
- **Reset mid-turn:** rst asserted while turn_valid=1 at index 1. Required: all outputs at reset values next cycle. A subsequent load replays from slot 0.
- **Load ignored while busy:** load in FOLLOW with different directions. Required: the original sequence continues unchanged. A load in DONE restarts with the new data.

Source files
------------

// File: rtl/turn_sequencer_pkg.sv
// rtl/turn_sequencer_pkg.sv - shared turn codes, sizing and state enum for the turn sequencer
package turn_sequencer_pkg;

    localparam int MAX_TURNS = 12;
    localparam int DIR_W     = 2;

    // Slot count as a 4-bit value so it compares cleanly against num_turns.
    localparam logic [3:0] MAX_TURNS_CNT = 4'(MAX_TURNS);

    // Codes shared with the path direction planner.
    typedef enum logic [DIR_W-1:0] {
        U_TURN   = 2'b00,
        LEFT     = 2'b01,
        RIGHT    = 2'b10,
        STRAIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FOLLOW = 2'b01,
        ST_TURN   = 2'b10,
        ST_DONE   = 2'b11
    } seq_state_t;

endpackage

// File: rtl/turn_sequencer.sv
// rtl/turn_sequencer.sv - replays planned per-node turns to the motor controller
module turn_sequencer
    import turn_sequencer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [MAX_TURNS*DIR_W-1:0] directions,
    input  logic [3:0]                 num_turns,
    input  logic                       node_detect,
    input  logic                       turn_done,
    output logic [DIR_W-1:0]           turn_cmd,
    output logic                       turn_valid,
    output logic [3:0]                 turn_index,
    output logic                       busy,
    output logic                       path_done,
    output logic                       overrun
);

    seq_state_t                 state;
    logic [MAX_TURNS*DIR_W-1:0] dirs_q;
    logic [3:0]                 count_q;
    logic [3:0]                 sat_turns;
    logic [3:0]                 next_index;
    logic [DIR_W-1:0]           slot;

    always_comb begin
        sat_turns  = (num_turns > MAX_TURNS_CNT) ? MAX_TURNS_CNT : num_turns;
        next_index = turn_index + 4'd1;
        // Only read in FOLLOW, where turn_index < count_q <= MAX_TURNS.
        slot       = dirs_q[int'(turn_index)*DIR_W +: DIR_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dirs_q     <= '0;
            count_q    <= '0;
            turn_cmd   <= U_TURN;
            turn_valid <= 1'b0;
            turn_index <= '0;
            busy       <= 1'b0;
            path_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load) begin
                        dirs_q     <= directions;
                        count_q    <= sat_turns;
                        turn_index <= '0;
                        overrun    <= 1'b0;
                        turn_valid <= 1'b0;
                        if (sat_turns == 4'd0) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            path_done <= 1'b1;
                        end else begin
                            state     <= ST_FOLLOW;
                            busy      <= 1'b1;
                            path_done <= 1'b0;
                        end
                    end
                end
                ST_FOLLOW: begin
                    if (node_detect) begin
                        turn_cmd   <= slot;
                        turn_valid <= 1'b1;
                        state      <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    // A node seen mid-turn is flagged, never queued.
                    if (node_detect) begin
                        overrun <= 1'b1;
                    end
                    if (turn_done) begin
                        turn_valid <= 1'b0;
                        turn_index <= next_index;
                        if (next_index == count_q) begin
                            state     <= ST_DONE;
                            busy      <= 1'b0;
                            path_done <= 1'b1;
                        end else begin
                            state <= ST_FOLLOW;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
